// File: rtl/data_mem_sized.sv
// data_mem_sized
//   Byte-addressed, little-endian data memory for the MIPS memory stage.
//   Handles byte/halfword/word loads and stores with sign or zero extension
//   on loads. Misaligned or illegal requests are rejected with a one-cycle
//   error pulse. After reset the array is cleared one aligned word per
//   cycle. Requests are accepted only while ready is high.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high; restarts the clear sequence
//   req_valid    request present
//   req_write    1 = store, 0 = load
//   req_size     00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned 1 = zero-extend loads, 0 = sign-extend (ignored on stores)
//   req_addr     byte address
//   req_wdata    store data, right-aligned
//   ready        a request can be accepted this cycle
//   busy         clear sequence in progress
//   rd_valid     one-cycle pulse, rd_data holds a new load result
//   rd_data      extended load result, held while rd_valid is low
//   misaligned   one-cycle pulse for a rejected request
module data_mem_sized #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic                   req_write,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_LENGTH-1:0] req_wdata,
  output logic                   ready,
  output logic                   busy,
  output logic                   rd_valid,
  output logic [DATA_LENGTH-1:0] rd_data,
  output logic                   misaligned
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned WORDS = DEPTH / 4;
  // Word counter width; kept at least one bit so the smallest legal
  // ADDR_WIDTH (2, a single word) still elaborates.
  localparam int unsigned CW    = (ADDR_WIDTH > 2) ? (ADDR_WIDTH - 2) : 1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [CW-1:0]           clr_q, clr_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_LENGTH-1:0]  rd_data_q, rd_data_d;
  logic                    mis_q, mis_d;

  logic [7:0]              mem [DEPTH];

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic                    clearing;
  logic                    accept;
  logic                    legal;
  logic                    do_store;
  logic                    do_load;
  logic [3:0]              lane_en;
  logic [ADDR_WIDTH-1:0]   lane_addr [4];
  logic [7:0]              lane_rd   [4];
  logic [ADDR_WIDTH-1:0]   clr_base;
  logic                    clr_last;

  logic [3:0]              wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr [4];
  logic [7:0]              wr_byte [4];

  logic [DATA_LENGTH-1:0]  load_val;
  logic                    ext_bit;

  assign clearing = (state_q == ST_CLEAR) && !reset;
  assign ready    = (state_q == ST_IDLE) && !reset;
  assign busy     = (state_q == ST_CLEAR);
  assign accept   = req_valid && ready;

  always_comb begin
    legal = 1'b0;
    case (req_size)
      SZ_BYTE: legal = 1'b1;
      SZ_HALF: legal = !req_addr[0];
      SZ_WORD: legal = (req_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  assign do_store = accept && legal && req_write;
  assign do_load  = accept && legal && !req_write;

  always_comb begin
    lane_en = 4'b0000;
    case (req_size)
      SZ_BYTE: lane_en = 4'b0001;
      SZ_HALF: lane_en = 4'b0011;
      SZ_WORD: lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  // Byte lane addresses wrap modulo the array size; legal accesses never
  // actually reach the wrap, it only keeps the index in range.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      lane_addr[k] = req_addr + ADDR_WIDTH'(k);
      lane_rd[k]   = mem[lane_addr[k]];
    end
  end

  // ---------------------------------------------------------------------
  // Clear sequencing
  // ---------------------------------------------------------------------
  assign clr_base = ADDR_WIDTH'({clr_q, 2'b00});
  assign clr_last = (clr_q == CW'(WORDS - 1));

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (clearing) begin
      clr_d = clr_q + 1'b1;
      if (clr_last) begin
        state_d = ST_IDLE;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Array write port: the clear and stores share the four byte lanes.
  // They never overlap because stores need ready, which is low in CLEAR.
  // ---------------------------------------------------------------------
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      if (clearing) begin
        wr_en[k]   = 1'b1;
        wr_addr[k] = clr_base + ADDR_WIDTH'(k);
        wr_byte[k] = '0;
      end else begin
        wr_en[k]   = do_store && lane_en[k];
        wr_addr[k] = lane_addr[k];
        wr_byte[k] = req_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 4; k++) begin
      if (wr_en[k]) begin
        mem[wr_addr[k]] <= wr_byte[k];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Load data extension
  // ---------------------------------------------------------------------
  always_comb begin
    load_val = '0;
    ext_bit  = 1'b0;
    case (req_size)
      SZ_BYTE: begin
        ext_bit  = !req_unsigned && lane_rd[0][7];
        load_val = {{24{ext_bit}}, lane_rd[0]};
      end
      SZ_HALF: begin
        ext_bit  = !req_unsigned && lane_rd[1][7];
        load_val = {{16{ext_bit}}, lane_rd[1], lane_rd[0]};
      end
      SZ_WORD: begin
        load_val = {lane_rd[3], lane_rd[2], lane_rd[1], lane_rd[0]};
      end
      default: load_val = '0;
    endcase
  end

  always_comb begin
    rd_valid_d = do_load;
    mis_d      = accept && !legal;
    rd_data_d  = do_load ? load_val : rd_data_q;
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      mis_q      <= mis_d;
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_data_mem_sized.sv
// Directed testbench for data_mem_sized (ADDR_WIDTH = 10).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_data_mem_sized;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        ready;
  logic        busy;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_sized #(
    .ADDR_WIDTH (10),
    .DATA_LENGTH(32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .ready       (ready),
    .busy        (busy),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .misaligned  (misaligned)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [9:0] a, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
  endtask

  // One request, then land in the cycle after acceptance.
  task automatic op(input logic w, input logic [1:0] sz, input logic uns,
                    input logic [9:0] a, input logic [31:0] wd);
    drive(w, sz, uns, a, wd);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic store(input string tag, input logic [1:0] sz, input logic [9:0] a,
                       input logic [31:0] wd);
    op(1'b1, sz, 1'b0, a, wd);
    check({tag, ".rd_valid"}, {31'd0, rd_valid}, 32'd0);
    check({tag, ".misaligned"}, {31'd0, misaligned}, 32'd0);
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input logic uns,
                      input logic [9:0] a, input logic [31:0] exp);
    op(1'b0, sz, uns, a, 32'd0);
    check({tag, ".rd_valid"}, {31'd0, rd_valid}, 32'd1);
    check({tag, ".misaligned"}, {31'd0, misaligned}, 32'd0);
    check({tag, ".rd_data"}, rd_data, exp);
  endtask

  task automatic reject(input string tag, input logic w, input logic [1:0] sz,
                        input logic [9:0] a, input logic [31:0] wd);
    op(w, sz, 1'b0, a, wd);
    check({tag, ".misaligned"}, {31'd0, misaligned}, 32'd1);
    check({tag, ".rd_valid"}, {31'd0, rd_valid}, 32'd0);
  endtask

  // Called at the falling edge right after reset drops.
  task automatic count_clear(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      if (ready !== 1'b0) begin
        check({tag, ".ready_during_clear"}, {31'd0, ready}, 32'd0);
      end
      @(negedge clk);
    end
    check({tag, ".busy_cycles"}, n, 32'd256);
    check({tag, ".ready"}, {31'd0, ready}, 32'd1);
    check({tag, ".busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;

    repeat (3) @(negedge clk);
    check("rst.ready", {31'd0, ready}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd1);
    check("rst.rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst.rd_data", rd_data, 32'd0);
    check("rst.misaligned", {31'd0, misaligned}, 32'd0);

    reset = 1'b0;
    count_clear("clr0");

    load("ld000", 2'b10, 1'b0, 10'h000, 32'h0000_0000);
    load("ld3fc", 2'b10, 1'b0, 10'h3FC, 32'h0000_0000);

    // Byte lanes and extension.
    store("st010", 2'b10, 10'h010, 32'h80FF_7F01);
    load("lb010s", 2'b00, 1'b0, 10'h010, 32'h0000_0001);
    load("lb011s", 2'b00, 1'b0, 10'h011, 32'h0000_007F);
    load("lb012s", 2'b00, 1'b0, 10'h012, 32'hFFFF_FFFF);
    load("lb013s", 2'b00, 1'b0, 10'h013, 32'hFFFF_FF80);
    load("lb012u", 2'b00, 1'b1, 10'h012, 32'h0000_00FF);
    store("sb011", 2'b00, 10'h011, 32'hFFFF_FF5A);
    load("lw010", 2'b10, 1'b0, 10'h010, 32'h80FF_5A01);

    // Halfword over word.
    store("st020", 2'b10, 10'h020, 32'h1122_3344);
    store("sh022", 2'b01, 10'h022, 32'h0000_BEEF);
    load("lw020", 2'b10, 1'b0, 10'h020, 32'hBEEF_3344);
    load("lh022s", 2'b01, 1'b0, 10'h022, 32'hFFFF_BEEF);
    load("lh022u", 2'b01, 1'b1, 10'h022, 32'h0000_BEEF);

    // Top of the array.
    store("sb3ff", 2'b00, 10'h3FF, 32'h0000_00A5);
    load("lb3ffs", 2'b00, 1'b0, 10'h3FF, 32'hFFFF_FFA5);
    store("sh3fe", 2'b01, 10'h3FE, 32'h0000_7E11);
    load("lw3fc", 2'b10, 1'b1, 10'h3FC, 32'h7E11_0000);

    // Rejected requests.
    store("st004", 2'b10, 10'h004, 32'hCAFE_BABE);
    reject("sw005", 1'b1, 2'b10, 10'h005, 32'hDEAD_BEEF);
    load("lw004a", 2'b10, 1'b0, 10'h004, 32'hCAFE_BABE);
    reject("lh003", 1'b0, 2'b01, 10'h003, 32'd0);
    check("lh003.rd_data_hold", rd_data, 32'hCAFE_BABE);
    load("lw004b", 2'b10, 1'b0, 10'h004, 32'hCAFE_BABE);
    reject("sz11", 1'b0, 2'b11, 10'h008, 32'd0);
    load("lw004c", 2'b10, 1'b0, 10'h004, 32'hCAFE_BABE);
    load("lb005s", 2'b00, 1'b0, 10'h005, 32'hFFFF_FFBA);

    // Store at edge N, load at edge N+1.
    drive(1'b1, 2'b10, 1'b0, 10'h040, 32'h1234_5678);
    @(negedge clk);
    check("b2b.st_rd_valid", {31'd0, rd_valid}, 32'd0);
    drive(1'b0, 2'b10, 1'b0, 10'h040, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b.ld_rd_valid", {31'd0, rd_valid}, 32'd1);
    check("b2b.ld_rd_data", rd_data, 32'h1234_5678);

    // Three loads in consecutive cycles.
    drive(1'b0, 2'b10, 1'b0, 10'h040, 32'd0);
    @(negedge clk);
    check("pipe1.rd_valid", {31'd0, rd_valid}, 32'd1);
    check("pipe1.rd_data", rd_data, 32'h1234_5678);
    drive(1'b0, 2'b10, 1'b0, 10'h010, 32'd0);
    @(negedge clk);
    check("pipe2.rd_valid", {31'd0, rd_valid}, 32'd1);
    check("pipe2.rd_data", rd_data, 32'h80FF_5A01);
    drive(1'b0, 2'b10, 1'b0, 10'h020, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("pipe3.rd_valid", {31'd0, rd_valid}, 32'd1);
    check("pipe3.rd_data", rd_data, 32'hBEEF_3344);
    @(negedge clk);
    check("pipe.idle_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("pipe.idle_rd_hold", rd_data, 32'hBEEF_3344);

    // Reset coinciding with a load request: nothing is returned.
    drive(1'b0, 2'b10, 1'b0, 10'h040, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst2.rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst2.misaligned", {31'd0, misaligned}, 32'd0);
    check("rst2.rd_data", rd_data, 32'd0);
    check("rst2.busy", {31'd0, busy}, 32'd1);
    check("rst2.ready", {31'd0, ready}, 32'd0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("clr_mid.busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_clear("clr1");
    load("lw040_cleared", 2'b10, 1'b0, 10'h040, 32'h0000_0000);
    load("lw004_cleared", 2'b10, 1'b0, 10'h004, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
